// File: rtl/pack_plateau_detector_pkg.sv
// Shared definitions for the preamble sync chain: detector state encoding,
// default threshold fractions and counter sizing.
package pack_plateau_detector_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CAND = 2'd1;
    localparam logic [1:0] ST_DET  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam int unsigned DEF_THR_SHIFT   = 4;
    localparam int unsigned DEF_THR_ON_NUM  = 12;
    localparam int unsigned DEF_THR_OFF_NUM = 8;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pack_thr_compare.sv
// Exact compare of corr_mag against NUM/2^THR_SHIFT of energy_mag, done at
// full width so neither side is truncated.
module pack_thr_compare #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned THR_SHIFT = 4,
    parameter int unsigned NUM       = 12
) (
    input  logic [DATA_W-1:0] corr_mag,
    input  logic [DATA_W-1:0] energy_mag,
    output logic              greater_c,
    output logic              less_c
);

    localparam int unsigned LHS_W = DATA_W + THR_SHIFT;
    localparam int unsigned RHS_W = DATA_W + $clog2(NUM + 1);
    localparam int unsigned CMP_W = (LHS_W > RHS_W) ? LHS_W : RHS_W;

    logic [CMP_W-1:0] lhs;
    logic [CMP_W-1:0] rhs;

    assign lhs       = CMP_W'(corr_mag) << THR_SHIFT;
    assign rhs       = CMP_W'(energy_mag) * CMP_W'(NUM);
    assign greater_c = lhs > rhs;
    assign less_c    = lhs < rhs;

endmodule

// File: rtl/pack_plateau_detector.sv
// Packet decision stage: hysteresis thresholds, minimum plateau with dropout
// tolerance, end-of-packet debounce and post-packet hold-off.
module pack_plateau_detector
    import pack_plateau_detector_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned THR_SHIFT   = DEF_THR_SHIFT,
    parameter int unsigned THR_ON_NUM  = DEF_THR_ON_NUM,
    parameter int unsigned THR_OFF_NUM = DEF_THR_OFF_NUM,
    parameter int unsigned MIN_PLATEAU = 16,
    parameter int unsigned MAX_MISS    = 1,
    parameter int unsigned END_CNT     = 4,
    parameter int unsigned HOLDOFF     = 32,
    parameter int unsigned LEN_W       = 16
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              clr,
    input  logic [DATA_W-1:0] prod_avg_mag,
    input  logic [DATA_W-1:0] mag_sq_avg,
    input  logic              prod_avg_mag_Strobe,
    output logic              Pack_det,
    output logic              pack_start,
    output logic              pack_end,
    output logic              pak_strobe,
    output logic [LEN_W-1:0]  plateau_len,
    output logic [1:0]        state_o
);

    localparam int unsigned RUN_W  = cnt_w(MIN_PLATEAU);
    localparam int unsigned MISS_W = cnt_w(MAX_MISS);
    localparam int unsigned DROP_W = cnt_w(END_CNT);
    localparam int unsigned HOLD_W = cnt_w(HOLDOFF);

    if (THR_OFF_NUM > THR_ON_NUM || MIN_PLATEAU == 0) begin : g_param_check
        $error("pack_plateau_detector: need THR_OFF_NUM <= THR_ON_NUM and MIN_PLATEAU >= 1");
    end

    logic              above;
    logic              below;
    logic              on_less_unused;
    logic              off_greater_unused;

    logic [1:0]        state, state_nxt;
    logic [RUN_W-1:0]  run, run_nxt;
    logic [MISS_W-1:0] miss, miss_nxt;
    logic [DROP_W-1:0] drop, drop_nxt;
    logic [HOLD_W-1:0] hcnt, hcnt_nxt;
    logic [LEN_W-1:0]  len_nxt, len_inc;
    logic              start_nxt, end_nxt;

    logic [RUN_W:0]    run_inc;
    logic [DROP_W:0]   drop_inc;
    logic [HOLD_W:0]   hcnt_inc;

    pack_thr_compare #(
        .DATA_W(DATA_W), .THR_SHIFT(THR_SHIFT), .NUM(THR_ON_NUM)
    ) u_cmp_on (
        .corr_mag(prod_avg_mag), .energy_mag(mag_sq_avg),
        .greater_c(above), .less_c(on_less_unused)
    );

    pack_thr_compare #(
        .DATA_W(DATA_W), .THR_SHIFT(THR_SHIFT), .NUM(THR_OFF_NUM)
    ) u_cmp_off (
        .corr_mag(prod_avg_mag), .energy_mag(mag_sq_avg),
        .greater_c(off_greater_unused), .less_c(below)
    );

    // Counter increments carry one spare bit so limit compares cannot wrap.
    assign run_inc  = (RUN_W+1)'(run) + (RUN_W+1)'(1);
    assign drop_inc = (DROP_W+1)'(drop) + (DROP_W+1)'(1);
    assign hcnt_inc = (HOLD_W+1)'(hcnt) + (HOLD_W+1)'(1);
    assign len_inc  = (plateau_len == {LEN_W{1'b1}}) ? plateau_len : plateau_len + LEN_W'(1);
    assign state_o  = state;

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        miss_nxt  = miss;
        drop_nxt  = drop;
        hcnt_nxt  = hcnt;
        len_nxt   = plateau_len;
        start_nxt = 1'b0;
        end_nxt   = 1'b0;
        if (clr) begin
            state_nxt = ST_IDLE;
            run_nxt   = '0;
            miss_nxt  = '0;
            drop_nxt  = '0;
            hcnt_nxt  = '0;
            len_nxt   = '0;
        end else if (prod_avg_mag_Strobe) begin
            case (state)
                ST_IDLE: begin
                    if (above) begin
                        run_nxt  = RUN_W'(1);
                        miss_nxt = '0;
                        drop_nxt = '0;
                        len_nxt  = LEN_W'(1);
                        if (MIN_PLATEAU == 1) begin
                            state_nxt = ST_DET;
                            start_nxt = 1'b1;
                        end else begin
                            state_nxt = ST_CAND;
                        end
                    end
                end
                ST_CAND: begin
                    if (above) begin
                        run_nxt  = RUN_W'(run_inc);
                        miss_nxt = '0;
                        len_nxt  = len_inc;
                        if (run_inc == (RUN_W+1)'(MIN_PLATEAU)) begin
                            state_nxt = ST_DET;
                            start_nxt = 1'b1;
                            drop_nxt  = '0;
                        end
                    end else if (miss == MISS_W'(MAX_MISS)) begin
                        state_nxt = ST_IDLE;
                        run_nxt   = '0;
                        miss_nxt  = '0;
                        len_nxt   = '0;
                    end else begin
                        miss_nxt = miss + MISS_W'(1);
                    end
                end
                ST_DET: begin
                    len_nxt = len_inc;
                    if (!below) begin
                        drop_nxt = '0;
                    end else if (drop_inc >= (DROP_W+1)'(END_CNT)) begin
                        state_nxt = ST_HOLD;
                        end_nxt   = 1'b1;
                        drop_nxt  = '0;
                        run_nxt   = '0;
                        miss_nxt  = '0;
                        hcnt_nxt  = '0;
                    end else begin
                        drop_nxt = DROP_W'(drop_inc);
                    end
                end
                ST_HOLD: begin
                    // Plateau length stays frozen here so downstream can read it.
                    if (hcnt_inc >= (HOLD_W+1)'(HOLDOFF)) begin
                        state_nxt = ST_IDLE;
                        hcnt_nxt  = '0;
                        len_nxt   = '0;
                    end else begin
                        hcnt_nxt = HOLD_W'(hcnt_inc);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state       <= ST_IDLE;
            run         <= '0;
            miss        <= '0;
            drop        <= '0;
            hcnt        <= '0;
            plateau_len <= '0;
            Pack_det    <= 1'b0;
            pack_start  <= 1'b0;
            pack_end    <= 1'b0;
            pak_strobe  <= 1'b0;
        end else begin
            state       <= state_nxt;
            run         <= run_nxt;
            miss        <= miss_nxt;
            drop        <= drop_nxt;
            hcnt        <= hcnt_nxt;
            plateau_len <= len_nxt;
            Pack_det    <= (state_nxt == ST_DET);
            pack_start  <= start_nxt;
            pack_end    <= end_nxt;
            pak_strobe  <= prod_avg_mag_Strobe;
        end
    end

endmodule
